// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and sizing for the UART TX control stage.
// DATA_WIDTH also sizes the controller's bit counter.
package uart_tx_ctrl_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic {
    PAR_EVEN,
    PAR_ODD
  } par_typ_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Producer/serializer-facing signals of uart_tx_ctrl.
// slave = controller side, master = producer/serializer side.
interface uart_tx_ctrl_if;
  import uart_tx_ctrl_pkg::*;

  logic                  i_baud_tick;
  logic                  i_data_valid;
  logic [DATA_WIDTH-1:0] i_P_DATA;
  logic                  i_par_en;
  logic                  i_par_typ;
  logic                  i_ser_data;

  logic                  o_ready;
  logic                  o_latch_en;
  logic                  o_ser_en;
  logic                  o_busy;
  logic                  o_tx;

  modport slave (
    input  i_baud_tick,
    input  i_data_valid,
    input  i_P_DATA,
    input  i_par_en,
    input  i_par_typ,
    input  i_ser_data,
    output o_ready,
    output o_latch_en,
    output o_ser_en,
    output o_busy,
    output o_tx
  );

  modport master (
    output i_baud_tick,
    output i_data_valid,
    output i_P_DATA,
    output i_par_en,
    output i_par_typ,
    output i_ser_data,
    input  o_ready,
    input  o_latch_en,
    input  o_ser_en,
    input  o_busy,
    input  o_tx
  );

endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Parity bit for one data word: reduction XOR, inverted for odd parity.
// Only built when UART_TX_PARITY_EN is defined.
`ifdef UART_TX_PARITY_EN
module parity_calc
  import uart_tx_ctrl_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_data,
  input  par_typ_t              i_par_typ,
  output logic                  o_par
);

  assign o_par = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule
`endif

// File: rtl/uart_tx_ctrl.sv
// UART TX frame controller: handshake, serializer strobes, registered TX line.
// Optional parity bit is compiled in with the UART_TX_PARITY_EN macro.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  uart_tx_ctrl_if.slave bus
);

  tx_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tx_q;
  logic             line_d;
  logic             accept;
  logic             last_bit;

  assign accept   = (state_q == IDLE) & bus.i_data_valid & bus.i_baud_tick;
  assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));

`ifdef UART_TX_PARITY_EN
  logic par_q;
  logic par_en_q;
  logic par_bit;

  parity_calc u_parity_calc (
    .i_data    (bus.i_P_DATA),
    .i_par_typ (par_typ_t'(bus.i_par_typ)),
    .o_par     (par_bit)
  );
`else
  // Parity inputs stay on the port list for a stable pin-out but are ignored.
  logic unused_par_inputs;
  assign unused_par_inputs = ^{bus.i_par_en, bus.i_par_typ, bus.i_P_DATA};
`endif

  always_comb begin
    line_d = 1'b1;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = bus.i_ser_data;
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = par_q;
`endif
      default: line_d = 1'b1;
    endcase
  end

  // Every transition waits for a baud tick; tx_q trails the state by one clock.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
`endif
    end else begin
      tx_q <= line_d;
      if (bus.i_baud_tick) begin
        case (state_q)
          IDLE: begin
            if (bus.i_data_valid) begin
              state_q  <= START;
`ifdef UART_TX_PARITY_EN
              par_q    <= par_bit;
              par_en_q <= bus.i_par_en;
`endif
            end
          end
          START: begin
            state_q <= DATA;
            cnt_q   <= '0;
          end
          DATA: begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              state_q <= par_en_q ? PARITY : STOP;
`else
              state_q <= STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY:  state_q <= STOP;
`endif
          STOP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_busy     = (state_q != IDLE);
  assign bus.o_latch_en = accept;
  // The shift lands on the same edge that closes the current data bit.
  assign bus.o_ser_en   = (state_q == DATA) & bus.i_baud_tick;
  assign bus.o_tx       = tx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with a behavioural serializer and a tick every 4 clocks.
// Frame length expectations follow whether UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  import uart_tx_ctrl_pkg::*;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Serializer model: latch on o_latch_en, shift right on o_ser_en.
  logic [DATA_WIDTH-1:0] sreg;
  always @(posedge clk) begin
    if (bus.o_latch_en)    sreg <= bus.i_P_DATA;
    else if (bus.o_ser_en) sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
  end
  assign bus.i_ser_data = sreg[0];

  bit          tick_en = 1'b1;
  int unsigned div     = 0;
  initial begin
    bus.i_baud_tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      div = (div + 1) % 4;
      bus.i_baud_tick = tick_en && (div == 3);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge where o_latch_en is seen (the cycle before the accept edge).
  task automatic wait_accept(input string tag, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.o_latch_en !== 1'b1 && waited < 64);
    chk($sformatf("%s_accept", tag), bus.o_latch_en, 1);
  endtask

  // Called at the negedge just before the accept edge; ends at the negedge after the frame.
  task automatic run_frame(input string tag, input logic [7:0] data, input bit with_par,
                           input bit par_bit, input bit keep_valid, input logic [7:0] next_data,
                           input bit flip_par);
    int         nbits;
    logic [11:0] frame;
    logic [3:0] s;
    bit         rdy_seen;
    bit         busy_all;
    int         ser_cnt;
    int         lat_cnt;
    nbits = with_par ? 11 : 10;
    frame = with_par ? {2'b00, 1'b1, par_bit, data, 1'b0} : {3'b000, 1'b1, data, 1'b0};
    @(posedge clk); #1;
    bus.i_data_valid = keep_valid;
    bus.i_P_DATA     = next_data;
    if (flip_par) begin
      bus.i_par_en  = ~bus.i_par_en;
      bus.i_par_typ = ~bus.i_par_typ;
    end
    @(negedge clk);
    chk($sformatf("%s_tx_lag", tag), bus.o_tx, 1);
    rdy_seen = bus.o_ready;
    busy_all = bus.o_busy;
    ser_cnt  = int'(bus.o_ser_en);
    lat_cnt  = int'(bus.o_latch_en);
    for (int b = 0; b < nbits; b++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        s[j] = bus.o_tx;
        if (4*b + j + 1 < 4*nbits) begin
          rdy_seen = rdy_seen | bus.o_ready;
          busy_all = busy_all & bus.o_busy;
          ser_cnt += int'(bus.o_ser_en);
          lat_cnt += int'(bus.o_latch_en);
        end
      end
      chk($sformatf("%s_bit%0d", tag, b), s, {4{frame[b]}});
    end
    chk($sformatf("%s_busy_span", tag), busy_all, 1);
    chk($sformatf("%s_busy_end", tag), bus.o_busy, 0);
    chk($sformatf("%s_ready_low", tag), rdy_seen, 0);
    chk($sformatf("%s_ser_en_cnt", tag), ser_cnt, 8);
    chk($sformatf("%s_latch_cnt", tag), lat_cnt, 0);
  endtask

  task automatic send(input string tag, input logic [7:0] d, input bit pe, input bit pt,
                      input bit pbit);
    int w;
    @(posedge clk); #1;
    bus.i_P_DATA     = d;
    bus.i_par_en     = pe;
    bus.i_par_typ    = pt;
    bus.i_data_valid = 1'b1;
    wait_accept(tag, w);
    run_frame(tag, d, PAR_BUILD && pe, pbit, 1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    int  w;
    bit  lat_any;
    bit  tx_all;
    bit  tick_any;
    bus.i_data_valid = 1'b0;
    bus.i_P_DATA     = '0;
    bus.i_par_en     = 1'b0;
    bus.i_par_typ    = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx", bus.o_tx, 1);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_latch", bus.o_latch_en, 0);
    chk("rst_ser_en", bus.o_ser_en, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
    send("a5_nopar", 8'hA5, 1'b0, 1'b0, 1'b0);
    // 0xA5 has four ones: even parity 0, odd parity 1
    send("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0);
    send("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b1);

    // Valid held high across two frames
    @(posedge clk); #1;
    bus.i_par_en     = 1'b0;
    bus.i_par_typ    = 1'b0;
    bus.i_P_DATA     = 8'h00;
    bus.i_data_valid = 1'b1;
    wait_accept("hold0", w);
    run_frame("hold0", 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    wait_accept("hold1", w);
    chk("hold_gap", w, 3);
    run_frame("hold1", 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Reset in the middle of data bit 3 of 0xF0 (bit 3 is 0)
    @(posedge clk); #1;
    bus.i_P_DATA     = 8'hF0;
    bus.i_data_valid = 1'b1;
    wait_accept("rstmid", w);
    @(posedge clk); #1;
    bus.i_data_valid = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("rstmid_pre_tx", bus.o_tx, 0);
    chk("rstmid_pre_busy", bus.o_busy, 1);
    rst = 1'b1;
    #1;
    chk("rstmid_tx", bus.o_tx, 1);
    chk("rstmid_busy", bus.o_busy, 0);
    chk("rstmid_ready", bus.o_ready, 1);
    chk("rstmid_ser_en", bus.o_ser_en, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send("after_rst_3c", 8'h3C, 1'b0, 1'b0, 1'b0);

    // Valid raised with the tick stopped for 10 clocks
    @(negedge clk);
    tick_en = 1'b0;
    @(posedge clk); #1;
    bus.i_par_en     = 1'b0;
    bus.i_P_DATA     = 8'h5A;
    bus.i_data_valid = 1'b1;
    lat_any  = 1'b0;
    tx_all   = 1'b1;
    tick_any = 1'b0;
    repeat (10) begin
      @(negedge clk);
      lat_any  = lat_any | bus.o_latch_en;
      tx_all   = tx_all & bus.o_tx;
      tick_any = tick_any | bus.i_baud_tick;
    end
    chk("notick_latch", lat_any, 0);
    chk("notick_tx_high", tx_all, 1);
    chk("notick_ready", bus.o_ready, 1);
    tick_en = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.i_baud_tick !== 1'b1 && w < 16);
    chk("notick_first_tick_accept", bus.o_latch_en, 1);
    run_frame("notick_5a", 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

    // 0x81 with parity requested, odd type: parity bit 1 when parity is built in
    send("p81", 8'h81, 1'b1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
